// File: rtl/shifter_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : shifter_pipe                                                  |
// | Description : Pipelined multi-mode barrel shifter (SLL/SRL/SRA/ROL/ROR/PASS) |
// |               with carry-out and zero flags, valid/ready flow control.      |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module shifter_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [2:0]               Mode,
    input  logic [$clog2(WIDTH)-1:0] Shift,
    input  logic [WIDTH-1:0]         In,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [WIDTH-1:0]         Out,
    output logic                     Carry,
    output logic                     Zero
);

    localparam int         c_log = $clog2(WIDTH);
    localparam logic [2:0] c_sll = 3'b000;
    localparam logic [2:0] c_srl = 3'b001;
    localparam logic [2:0] c_sra = 3'b010;
    localparam logic [2:0] c_rol = 3'b011;
    localparam logic [2:0] c_ror = 3'b100;

    logic [STAGES-1:0]                  r_valid;
    logic [STAGES-1:0][WIDTH-1:0]       r_data;
    logic [STAGES-1:0][2:0]             r_mode;
    logic [STAGES-1:0][c_log-1:0]       r_shift;
    logic [STAGES-1:0]                  r_carry;
    logic                               r_zero;

    logic [STAGES-1:0]                  w_adv;
    logic [STAGES-1:0]                  w_src_valid;
    logic [STAGES-1:0][WIDTH-1:0]       w_src_data;
    logic [STAGES-1:0][2:0]             w_src_mode;
    logic [STAGES-1:0][c_log-1:0]       w_src_shift;
    logic [STAGES-1:0]                  w_src_carry;
    logic [STAGES-1:0][WIDTH-1:0]       w_nxt_data;

    logic                               w_carry0;
    logic [c_log-1:0]                   w_lidx;
    logic [c_log-1:0]                   w_ridx;
    logic                               w_left;
    logic                               w_unused;

    // One shift layer by a fixed power-of-two amount; SRA refills from the
    // current MSB, which still equals the operand's sign bit.
    function automatic logic [WIDTH-1:0] layer(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       m,
        input int               n
    );
        logic [WIDTH-1:0] r;
        case (m)
            c_sll:   r = d << n;
            c_srl:   r = d >> n;
            c_sra:   r = $signed(d) >>> n;
            c_rol:   r = (d << n) | (d >> (WIDTH - n));
            c_ror:   r = (d >> n) | (d << (WIDTH - n));
            default: r = d;
        endcase
        return r;
    endfunction

    // Carry taps the original operand: left modes see In[WIDTH-s], right modes
    // In[s-1]; for rotates these are exactly result[0] / result[WIDTH-1].
    always_comb begin
        w_lidx   = '0 - Shift;
        w_ridx   = Shift - {{(c_log-1){1'b0}}, 1'b1};
        w_left   = (Mode == c_sll) || (Mode == c_rol);
        w_carry0 = 1'b0;
        if ((Shift != '0) && (Mode <= c_ror)) begin
            w_carry0 = w_left ? In[w_lidx] : In[w_ridx];
        end
    end

    always_comb begin
        w_adv[STAGES-1] = !r_valid[STAGES-1] || OutReady;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k] = !r_valid[k] || w_adv[k+1];
        end
    end

    always_comb begin
        w_src_valid[0] = InValid;
        w_src_data[0]  = In;
        w_src_mode[0]  = Mode;
        w_src_shift[0] = Shift;
        w_src_carry[0] = w_carry0;
        for (int k = 1; k < STAGES; k++) begin
            w_src_valid[k] = r_valid[k-1];
            w_src_data[k]  = r_data[k-1];
            w_src_mode[k]  = r_mode[k-1];
            w_src_shift[k] = r_shift[k-1];
            w_src_carry[k] = r_carry[k-1];
        end
    end

    // Layer j lives in stage floor(j*STAGES/log2(WIDTH)).
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_nxt_data[k] = w_src_data[k];
            for (int j = 0; j < c_log; j++) begin
                if ((((j * STAGES) / c_log) == k) && w_src_shift[k][j]) begin
                    w_nxt_data[k] = layer(w_nxt_data[k], w_src_mode[k], 1 << j);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_valid <= '0;
            r_data  <= '0;
            r_mode  <= '0;
            r_shift <= '0;
            r_carry <= '0;
            r_zero  <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= w_src_valid[k];
                    if (w_src_valid[k]) begin
                        r_data[k]  <= w_nxt_data[k];
                        r_mode[k]  <= w_src_mode[k];
                        r_shift[k] <= w_src_shift[k];
                        r_carry[k] <= w_src_carry[k];
                    end
                end
            end
            if (w_adv[STAGES-1] && w_src_valid[STAGES-1]) begin
                r_zero <= (w_nxt_data[STAGES-1] == '0);
            end
        end
    end

    // Last-stage mode/amount and already-applied amount bits have no consumer.
    assign w_unused = ^{r_mode, r_shift};

    assign InReady  = w_adv[0];
    assign OutValid = r_valid[STAGES-1];
    assign Out      = r_data[STAGES-1];
    assign Carry    = r_carry[STAGES-1];
    assign Zero     = r_zero;

endmodule
`default_nettype wire
